// File: rtl/alu_acc_seq.sv
// Accumulator/flag sequencer wrapped around the 8080 ALU: decodes ALU-group opcodes,
// fetches operand B (register, immediate or memory) and writes result/flags back to A/PSW.
module alu_acc_seq #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] opcode,
    input  logic [7:0] regval,
    input  logic [7:0] immval,
    output logic       mem_req,
    input  logic       mem_ack,
    input  logic [7:0] mem_data,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic       alu_cin,
    output logic [2:0] alu_sel,
    input  logic [7:0] alu_res,
    input  logic       alu_cout,
    input  logic       alu_zout,
    input  logic       alu_sout,
    input  logic       alu_parity,
    input  logic       alu_auxcar,
    input  logic       acc_ld,
    input  logic [7:0] acc_din,
    input  logic       psw_ld,
    input  logic [7:0] psw_din,
    output logic [7:0] acc,
    output logic [7:0] flags,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {IDLE, MEMRD, EXEC, WB} state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] opb;
    logic [7:0] timer;

    logic       is_reg;
    logic       is_mem;
    logic       is_imm;
    logic       legal;
    logic       accept;
    logic       timeout;
    logic       logic_op;
    logic       new_cy;
    logic       new_ac;
    logic [7:0] new_flags;

    // PSW bits 5, 3 and 1 are hard-wired, so those input bits are never read.
    logic unused_psw_bits;
    assign unused_psw_bits = ^{psw_din[5], psw_din[3], psw_din[1]};

    assign is_reg  = (opcode[7:6] == 2'b10);
    assign is_mem  = is_reg && (opcode[2:0] == 3'b110);
    assign is_imm  = (opcode[7:6] == 2'b11) && (opcode[2:0] == 3'b110);
    assign legal   = is_reg || is_imm;
    assign accept  = start && ((state == IDLE) || (state == WB));
    assign timeout = (state == MEMRD) && !mem_ack && (timer == TIMEOUT_LAST);

    // Logic ops (ANA/XRA/ORA) clear CY; ANA takes AC from bit 3 of its operands.
    assign logic_op  = alu_sel[2] && (alu_sel != 3'b111);
    assign new_cy    = logic_op ? 1'b0 : alu_cout;
    assign new_ac    = (alu_sel == 3'b100) ? (acc[3] | opb[3]) :
                       logic_op            ? 1'b0 : alu_auxcar;
    assign new_flags = {alu_sout, alu_zout, 1'b0, new_ac, 1'b0, alu_parity, 1'b1, new_cy};

    assign alu_a   = acc;
    assign alu_b   = opb;
    assign alu_cin = flags[0];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE, WB: begin
                if (accept && legal) state_next = is_mem ? MEMRD : EXEC;
                else                 state_next = IDLE;
            end
            MEMRD: begin
                if (mem_ack)      state_next = EXEC;
                else if (timeout) state_next = IDLE;
            end
            EXEC:    state_next = WB;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_req = (state == MEMRD);
        busy    = (state == MEMRD) || (state == EXEC);
        done    = (state == WB);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc     <= 8'h00;
            flags   <= 8'h02;
            opb     <= 8'h00;
            alu_sel <= 3'b000;
            timer   <= 8'h00;
            err     <= 1'b0;
        end else begin
            err <= (accept && !legal) || timeout;

            // External loads land before a same-cycle start reaches EXEC.
            if (state == IDLE) begin
                if (acc_ld) acc <= acc_din;
                if (psw_ld) flags <= {psw_din[7:6], 1'b0, psw_din[4], 1'b0, psw_din[2], 1'b1, psw_din[0]};
            end

            if (accept && legal) begin
                alu_sel <= opcode[5:3];
                timer   <= 8'h00;
                if (!is_mem) opb <= is_imm ? immval : regval;
            end

            if (state == MEMRD) begin
                timer <= timer + 8'h01;
                if (mem_ack) opb <= mem_data;
            end

            if (state == EXEC) begin
                acc   <= alu_res;
                flags <= new_flags;
            end
        end
    end

endmodule

// File: tb/tb_alu_acc_seq.sv
// Self-checking bench for alu_acc_seq: behavioural 8080 ALU, vector table and
// hand-written memory/timeout/reset sequences, with a scoreboard of expected A/PSW.
module tb_alu_acc_seq;

    localparam int TO = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] opcode;
    logic [7:0] regval;
    logic [7:0] immval;
    logic       mem_req;
    logic       mem_ack;
    logic [7:0] mem_data;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_cin;
    logic [2:0] alu_sel;
    logic [7:0] alu_res;
    logic       alu_cout;
    logic       alu_zout;
    logic       alu_sout;
    logic       alu_parity;
    logic       alu_auxcar;
    logic       acc_ld;
    logic [7:0] acc_din;
    logic       psw_ld;
    logic [7:0] psw_din;
    logic [7:0] acc;
    logic [7:0] flags;
    logic       busy;
    logic       done;
    logic       err;

    alu_acc_seq #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode),
        .regval(regval), .immval(immval), .mem_req(mem_req), .mem_ack(mem_ack),
        .mem_data(mem_data), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
        .alu_sel(alu_sel), .alu_res(alu_res), .alu_cout(alu_cout), .alu_zout(alu_zout),
        .alu_sout(alu_sout), .alu_parity(alu_parity), .alu_auxcar(alu_auxcar),
        .acc_ld(acc_ld), .acc_din(acc_din), .psw_ld(psw_ld), .psw_din(psw_din),
        .acc(acc), .flags(flags), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Behavioural 8080 ALU. CY/AC are borrows for subtract; CMP returns A but flags the difference.
    // For logic ops the ALU's CY/AC are don't-care; drive 1 so the sequencer's override shows.
    always_comb begin
        logic [8:0] s;
        logic [4:0] h;
        logic       c;
        s = 9'h000;
        h = 5'h00;
        c = 1'b0;
        alu_cout   = 1'b0;
        alu_auxcar = 1'b0;
        case (alu_sel)
            3'b000, 3'b001: begin
                c = alu_sel[0] & alu_cin;
                s = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, c};
                h = {1'b0, alu_a[3:0]} + {1'b0, alu_b[3:0]} + {4'h0, c};
                alu_cout = s[8]; alu_auxcar = h[4];
            end
            3'b010, 3'b011, 3'b111: begin
                c = (alu_sel == 3'b011) & alu_cin;
                s = {1'b0, alu_a} - {1'b0, alu_b} - {8'h00, c};
                h = {1'b0, alu_a[3:0]} - {1'b0, alu_b[3:0]} - {4'h0, c};
                alu_cout = s[8]; alu_auxcar = h[4];
            end
            3'b100:  begin s = {1'b0, alu_a & alu_b}; alu_cout = 1'b1; alu_auxcar = 1'b1; end
            3'b101:  begin s = {1'b0, alu_a ^ alu_b}; alu_cout = 1'b1; alu_auxcar = 1'b1; end
            default: begin s = {1'b0, alu_a | alu_b}; alu_cout = 1'b1; alu_auxcar = 1'b1; end
        endcase
        alu_res    = (alu_sel == 3'b111) ? alu_a : s[7:0];
        alu_zout   = (s[7:0] == 8'h00);
        alu_sout   = s[7];
        alu_parity = ~^s[7:0];
    end

    typedef struct {
        logic [7:0] acc_init;
        logic [7:0] psw_init;
        logic [7:0] op;
        logic [7:0] rv;
        logic [7:0] iv;
        logic [7:0] exp_acc;
        logic [7:0] exp_flags;
    } vec_t;

    typedef struct {
        logic [7:0] acc;
        logic [7:0] flags;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called one cycle after the start edge; returns cycles from start edge to done.
    task automatic wait_done(output int n);
        n = 1;
        while (done !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic push_exp(input logic [7:0] a, input logic [7:0] f);
        exp_t e;
        e.acc   = a;
        e.flags = f;
        sb.push_back(e);
    endtask

    task automatic pop_check(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            check({name, " scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({name, " acc"}, 32'(acc), 32'(e.acc));
            check({name, " flags"}, 32'(flags), 32'(e.flags));
        end
    endtask

    task automatic do_start(input logic [7:0] op, input logic [7:0] rv, input logic [7:0] iv);
        start  = 1'b1;
        opcode = op;
        regval = rv;
        immval = iv;
        tick();
        start = 1'b0;
    endtask

    vec_t vecs[10];

    initial begin
        int n;
        int pulses;

        vecs[0] = '{8'h3A, 8'h02, 8'h80, 8'hC6, 8'h00, 8'h00, 8'h57}; // ADD B
        vecs[1] = '{8'h05, 8'h02, 8'hFE, 8'h00, 8'h07, 8'h05, 8'h93}; // CPI
        vecs[2] = '{8'h08, 8'h02, 8'hA0, 8'h01, 8'h00, 8'h00, 8'h56}; // ANA B
        vecs[3] = '{8'h10, 8'h03, 8'h89, 8'h0F, 8'h00, 8'h20, 8'h12}; // ADC C, CY=1
        vecs[4] = '{8'h10, 8'h03, 8'h9A, 8'h0F, 8'h00, 8'h00, 8'h56}; // SBB D, CY=1
        vecs[5] = '{8'h5A, 8'h03, 8'hEE, 8'h00, 8'hFF, 8'hA5, 8'h86}; // XRI
        vecs[6] = '{8'h00, 8'h03, 8'hB3, 8'h00, 8'h00, 8'h00, 8'h46}; // ORA E
        vecs[7] = '{8'h00, 8'h02, 8'h90, 8'h01, 8'h00, 8'hFF, 8'h97}; // SUB B
        vecs[8] = '{8'hF0, 8'h02, 8'hE6, 8'h00, 8'h37, 8'h30, 8'h06}; // ANI
        vecs[9] = '{8'h7F, 8'h02, 8'hC6, 8'h00, 8'h01, 8'h80, 8'h92}; // ADI

        reset = 1'b1; start = 1'b0; opcode = 8'h00; regval = 8'h00; immval = 8'h00;
        mem_ack = 1'b0; mem_data = 8'h00; acc_ld = 1'b0; acc_din = 8'h00;
        psw_ld = 1'b0; psw_din = 8'h00;
        tick();
        tick();
        check("reset acc", 32'(acc), 32'h00);
        check("reset flags", 32'(flags), 32'h02);
        check("reset busy", 32'(busy), 32'd0);
        check("reset mem_req", 32'(mem_req), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset err", 32'(err), 32'd0);
        check("reset alu_sel", 32'(alu_sel), 32'd0);
        check("reset alu_b", 32'(alu_b), 32'h00);
        reset = 1'b0;

        // Simultaneous A and PSW load; PSW fixed bits are forced.
        acc_ld = 1'b1; acc_din = 8'hA5; psw_ld = 1'b1; psw_din = 8'hFF;
        tick();
        acc_ld = 1'b0; psw_ld = 1'b0;
        check("load acc", 32'(acc), 32'hA5);
        check("load psw forced", 32'(flags), 32'hD7);

        for (int i = 0; i < 10; i++) begin
            acc_ld = 1'b1; acc_din = vecs[i].acc_init;
            psw_ld = 1'b1; psw_din = vecs[i].psw_init;
            tick();
            acc_ld = 1'b0; psw_ld = 1'b0;
            push_exp(vecs[i].exp_acc, vecs[i].exp_flags);
            do_start(vecs[i].op, vecs[i].rv, vecs[i].iv);
            check($sformatf("vec%0d busy", i), 32'(busy), 32'd1);
            check($sformatf("vec%0d alu_sel", i), 32'(alu_sel), 32'(vecs[i].op[5:3]));
            check($sformatf("vec%0d alu_b", i), 32'(alu_b),
                  32'((vecs[i].op[7:6] == 2'b11) ? vecs[i].iv : vecs[i].rv));
            wait_done(n);
            check($sformatf("vec%0d latency", i), 32'(n), 32'd2);
            pop_check($sformatf("vec%0d", i));
            tick();
        end

        // acc_ld together with start: EXEC sees the loaded A (01 + 01).
        acc_ld = 1'b1; acc_din = 8'h01;
        push_exp(8'h02, 8'h02);
        do_start(8'h80, 8'h01, 8'h00);
        acc_ld = 1'b0;
        wait_done(n);
        check("ld+start latency", 32'(n), 32'd2);
        pop_check("ld+start");

        // New start accepted in the WB cycle (02 + 01).
        push_exp(8'h03, 8'h06);
        do_start(8'h80, 8'h01, 8'h00);
        check("b2b busy", 32'(busy), 32'd1);
        wait_done(n);
        check("b2b latency", 32'(n), 32'd2);
        pop_check("b2b");
        tick();

        // ORA M with late ack; loads while busy must be ignored.
        acc_ld = 1'b1; acc_din = 8'h0F;
        tick();
        acc_ld = 1'b0;
        push_exp(8'hFF, 8'h86);
        do_start(8'hB6, 8'h00, 8'h00);
        check("memrd mem_req", 32'(mem_req), 32'd1);
        for (int i = 0; i < 3; i++) begin
            acc_ld = 1'b1; acc_din = 8'h55; psw_ld = 1'b1; psw_din = 8'h00;
            tick();
            check($sformatf("memrd wait%0d mem_req", i), 32'(mem_req), 32'd1);
        end
        acc_ld = 1'b0; psw_ld = 1'b0;
        check("busy ld ignored acc", 32'(acc), 32'h0F);
        check("busy ld ignored flags", 32'(flags), 32'h06);
        mem_ack = 1'b1; mem_data = 8'hF0;
        tick();
        mem_ack = 1'b0; mem_data = 8'h3C;
        check("mem_req after ack", 32'(mem_req), 32'd0);
        wait_done(n);
        check("mem latency", 32'(n), 32'd2);
        pop_check("ora_m");
        tick();

        // Illegal opcodes: err pulse next cycle, nothing else changes.
        do_start(8'h40, 8'h00, 8'h00);
        check("illegal40 err", 32'(err), 32'd1);
        check("illegal40 busy", 32'(busy), 32'd0);
        tick();
        check("illegal40 err clear", 32'(err), 32'd0);
        do_start(8'hC7, 8'h00, 8'h00);
        check("illegalC7 err", 32'(err), 32'd1);
        check("illegalC7 mem_req", 32'(mem_req), 32'd0);
        tick();
        check("illegal acc", 32'(acc), 32'hFF);
        check("illegal flags", 32'(flags), 32'h86);

        // SUB M with no ack: timeout.
        do_start(8'h96, 8'h00, 8'h00);
        n = 0;
        while (mem_req === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        check("timeout cycles", 32'(n), 32'(TO));
        check("timeout err", 32'(err), 32'd1);
        check("timeout done", 32'(done), 32'd0);
        check("timeout acc", 32'(acc), 32'hFF);
        check("timeout flags", 32'(flags), 32'h86);
        tick();
        check("timeout err clear", 32'(err), 32'd0);

        // Reset in the middle of MEMRD.
        do_start(8'h96, 8'h00, 8'h00);
        tick();
        tick();
        check("pre-reset mem_req", 32'(mem_req), 32'd1);
        reset = 1'b1;
        tick();
        check("midreset acc", 32'(acc), 32'h00);
        check("midreset flags", 32'(flags), 32'h02);
        check("midreset mem_req", 32'(mem_req), 32'd0);
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset alu_sel", 32'(alu_sel), 32'd0);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1 || err === 1'b1) pulses++;
            tick();
        end
        check("midreset no pulse", 32'(pulses), 32'd0);
        check("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
